// File: rtl/transmitter_i2s.sv
// transmitter_i2s
// I2S serial transmitter running directly on the bit clock. Stereo PCM pairs
// arrive over a valid/ready handshake into a 2-entry FIFO. Each 64-slot frame
// sends the left word MSB-first in slots 1..DATA_SIZE and the right word in
// slots 33..32+DATA_SIZE. WS leads each channel MSB by one bit clock.
//
// Parameters:
//   DATA_SIZE     bits per channel sample (8..31)
// Ports:
//   clk           bit clock, all logic on posedge
//   rst           synchronous active-high reset
//   sample_valid  upstream offers a {left,right} pair
//   sample_ready  FIFO can accept a pair this cycle (registered)
//   sample_left   left channel sample, two's complement
//   sample_right  right channel sample, two's complement
//   i2s_sd        serial data (registered)
//   i2s_ws        word select, 0 = left, 1 = right (registered)
//   underrun      one-cycle pulse in slot 1 when a frame started with an empty FIFO
//
// Optional feature macro: TX_I2S_REPEAT_ON_UNDERRUN_EN
//   defined   -> an underrun frame repeats the previously transmitted pair
//   undefined -> an underrun frame is silent (all zeros)
module transmitter_i2s #(
  parameter int DATA_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [DATA_SIZE-1:0] sample_left,
  input  logic [DATA_SIZE-1:0] sample_right,
  output logic                 i2s_sd,
  output logic                 i2s_ws,
  output logic                 underrun
);

  localparam logic [5:0] DS6 = 6'(DATA_SIZE);

  logic [5:0]           slot_r;
  logic [5:0]           slot_nxt_s;
  logic [DATA_SIZE-1:0] fifo_left_r  [2];
  logic [DATA_SIZE-1:0] fifo_right_r [2];
  logic                 wr_ptr_r;
  logic                 rd_ptr_r;
  logic [1:0]           count_r;
  logic [1:0]           count_nxt_s;
  logic [DATA_SIZE-1:0] left_r;
  logic [DATA_SIZE-1:0] right_r;
  logic [DATA_SIZE-1:0] left_nxt_s;
  logic [DATA_SIZE-1:0] right_nxt_s;
  logic [DATA_SIZE-1:0] shifted_s;
  logic [5:0]           idx_s;
  logic                 load_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 sd_nxt_s;

  // Handshake, frame-load and FIFO occupancy decisions for this edge
  always_comb begin
    slot_nxt_s = slot_r + 6'd1;
    load_s     = (slot_r == 6'd0);
    push_s     = sample_valid && sample_ready;
    pop_s      = load_s && (count_r != 2'd0);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next contents of the channel holding registers; they change only on the
  // slot-0 load edge so upstream activity never disturbs the frame in flight
  always_comb begin
    left_nxt_s  = left_r;
    right_nxt_s = right_r;
    if (pop_s) begin
      left_nxt_s  = fifo_left_r[rd_ptr_r];
      right_nxt_s = fifo_right_r[rd_ptr_r];
    end else if (load_s) begin
`ifdef TX_I2S_REPEAT_ON_UNDERRUN_EN
      // Keep the last pair so the line level stays steady during starvation
      left_nxt_s  = left_r;
      right_nxt_s = right_r;
`else
      left_nxt_s  = {DATA_SIZE{1'b0}};
      right_nxt_s = {DATA_SIZE{1'b0}};
`endif
    end else begin
      left_nxt_s  = left_r;
      right_nxt_s = right_r;
    end
  end

  // Bit that i2s_sd must present during the next slot. The next-state holding
  // values are used so slot 1 can show the MSB popped on the same edge.
  always_comb begin
    idx_s     = 6'd0;
    shifted_s = {DATA_SIZE{1'b0}};
    sd_nxt_s  = 1'b0;
    if ((slot_nxt_s >= 6'd1) && (slot_nxt_s <= DS6)) begin
      idx_s     = DS6 - slot_nxt_s;
      shifted_s = left_nxt_s >> idx_s;
      sd_nxt_s  = shifted_s[0];
    end else if ((slot_nxt_s >= 6'd33) && (slot_nxt_s <= (DS6 + 6'd32))) begin
      idx_s     = DS6 + 6'd32 - slot_nxt_s;
      shifted_s = right_nxt_s >> idx_s;
      sd_nxt_s  = shifted_s[0];
    end else begin
      sd_nxt_s  = 1'b0;
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked by count_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_left_r[wr_ptr_r]  <= sample_left;
      fifo_right_r[wr_ptr_r] <= sample_right;
    end
  end

  // Frame counter, FIFO pointers, holding registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r       <= 6'd0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
      left_r       <= {DATA_SIZE{1'b0}};
      right_r      <= {DATA_SIZE{1'b0}};
      sample_ready <= 1'b1;
      i2s_sd       <= 1'b0;
      i2s_ws       <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      slot_r       <= slot_nxt_s;
      if (push_s) begin
        wr_ptr_r   <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r   <= ~rd_ptr_r;
      end
      count_r      <= count_nxt_s;
      left_r       <= left_nxt_s;
      right_r      <= right_nxt_s;
      sample_ready <= (count_nxt_s < 2'd2);
      i2s_sd       <= sd_nxt_s;
      i2s_ws       <= slot_nxt_s[5];
      underrun     <= load_s && (count_r == 2'd0);
    end
  end

endmodule

// File: tb/tb_transmitter_i2s.sv
// tb_transmitter_i2s
// Self-checking bench for transmitter_i2s. A frame-level reference model
// (queue of pending pairs plus the 64-bit list of the frame being sent)
// predicts every output in every cycle. A second DATA_SIZE=16 instance covers
// the narrow-word case with constant expectations.
module tb_transmitter_i2s;

  localparam int DS = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sample_valid;
  logic          sample_ready;
  logic [DS-1:0] sample_left;
  logic [DS-1:0] sample_right;
  logic          i2s_sd;
  logic          i2s_ws;
  logic          underrun;

  logic          v16;
  logic          rdy16;
  logic [15:0]   l16;
  logic [15:0]   r16;
  logic          sd16;
  logic          ws16;
  logic          ur16;

  transmitter_i2s #(.DATA_SIZE(DS)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .i2s_sd       (i2s_sd),
    .i2s_ws       (i2s_ws),
    .underrun     (underrun)
  );

  transmitter_i2s #(.DATA_SIZE(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (v16),
    .sample_ready (rdy16),
    .sample_left  (l16),
    .sample_right (r16),
    .i2s_sd       (sd16),
    .i2s_ws       (ws16),
    .underrun     (ur16)
  );

  int              checks_cnt = 0;
  int              errors_cnt = 0;
  logic [2*DS-1:0] pend_q [$];
  logic            frame_bits [64];
  int              slot_m   = 0;
  int              frame_no = 0;
  int              cyc      = 0;
  bit              ur_frame = 1'b0;
  bit              accepted = 1'b0;
  bit              chk16    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s cyc=%0d slot=%0d observed=%0h required=%0h", tag, cyc, slot_m, obs, exp);
    end
  endtask

  // Expected frame: bits listed in transmit order, zeros everywhere else
  task automatic build_frame(input logic [DS-1:0] l, input logic [DS-1:0] r);
    for (int i = 0; i < 64; i++) frame_bits[i] = 1'b0;
    for (int b = 0; b < DS; b++) begin
      frame_bits[1 + b]  = l[DS-1-b];
      frame_bits[33 + b] = r[DS-1-b];
    end
  endtask

  // Apply what happened at the clock edge that just occurred
  task automatic model_edge();
    logic [2*DS-1:0] e;
    bit rdy;
    cyc++;
    if (rst) begin
      pend_q.delete();
      slot_m   = 0;
      frame_no = 0;
      ur_frame = 1'b0;
      accepted = 1'b0;
      build_frame('0, '0);
    end else begin
      rdy      = (pend_q.size() < 2);
      accepted = sample_valid && rdy;
      if (slot_m == 0) begin
        if (pend_q.size() > 0) begin
          e = pend_q.pop_front();
          build_frame(e[2*DS-1:DS], e[DS-1:0]);
          ur_frame = 1'b0;
        end else begin
          ur_frame = 1'b1;
`ifndef TX_I2S_REPEAT_ON_UNDERRUN_EN
          build_frame('0, '0);
`endif
        end
      end
      if (accepted) pend_q.push_back({sample_left, sample_right});
      slot_m = (slot_m + 1) % 64;
      if (slot_m == 0) frame_no++;
    end
  endtask

  task automatic check_outputs();
    bit exp16;
    check_eq("ws", i2s_ws, slot_m >= 32);
    check_eq("sd", i2s_sd, frame_bits[slot_m]);
    check_eq("underrun", underrun, ur_frame && (slot_m == 1));
    check_eq("ready", sample_ready, pend_q.size() < 2);
    if (chk16 && frame_no < 2) begin
      exp16 = (frame_no == 1) && (((slot_m >= 1) && (slot_m <= 16)) || (slot_m == 48));
      check_eq("sd16", sd16, exp16);
      check_eq("ws16", ws16, slot_m >= 32);
      check_eq("underrun16", ur16, (frame_no == 0) && (slot_m == 1));
      check_eq("ready16", rdy16, 1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (slot_m != s && n < 200) begin
      tick();
      n++;
    end
    check_eq("wait_slot_timeout", slot_m, s);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pend_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", pend_q.size(), 0);
  endtask

  task automatic send(input logic [DS-1:0] l, input logic [DS-1:0] r);
    int n = 0;
    sample_valid = 1'b1;
    sample_left  = l;
    sample_right = r;
    do begin
      tick();
      n++;
    end while (!accepted && n < 300);
    check_eq("send_timeout", accepted, 1'b1);
    sample_valid = 1'b0;
  endtask

  initial begin
    int c1;
    int c2;
    int p;
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    v16          = 1'b0;
    l16          = 16'h0000;
    r16          = 16'h0000;
    build_frame('0, '0);
    tick();
    tick();
    rst = 1'b0;

    // Scenario 1: push on the edge ending slot 5, first frame silent
    chk16 = 1'b1;
    wait_slot(5);
    sample_valid = 1'b1;
    sample_left  = 24'hA5A5A5;
    sample_right = 24'h5A5A5A;
    v16          = 1'b1;
    l16          = 16'hFFFF;
    r16          = 16'h0001;
    tick();
    check_eq("s1_accept", accepted, 1'b1);
    sample_valid = 1'b0;
    v16          = 1'b0;
    run(140);
    chk16 = 1'b0;

    // Scenario 2: three pairs back to back from slot 10
    wait_drain();
    wait_slot(10);
    send(24'h111111, 24'h222222);
    c1 = cyc;
    send(24'h333333, 24'h444444);
    c2 = cyc;
    check_eq("b2b_gap", c2 - c1, 1);
    send(24'h555555, 24'h666666);
    check_eq("p3_gap", cyc - c2, 54);
    check_eq("p3_slot", slot_m, 2);
    run(10);

    // Scenario 3: empty FIFO, push exactly on the load edge
    wait_drain();
    wait_slot(0);
    sample_valid = 1'b1;
    sample_left  = 24'h800000;
    sample_right = 24'h7FFFFF;
    tick();
    check_eq("s3_accept", accepted, 1'b1);
    sample_valid = 1'b0;
    run(140);

    // Scenario 4: single pair pushed on the edge ending slot 63, then starve
    wait_drain();
    wait_slot(63);
    sample_valid = 1'b1;
    sample_left  = 24'h123456;
    sample_right = 24'h654321;
    tick();
    check_eq("s4_accept", accepted, 1'b1);
    sample_valid = 1'b0;
    tick();
    check_eq("s4_msb", i2s_sd, 1'b0);
    run(200);

    // Scenario 5: reset in slot 40 with two pairs queued
    wait_drain();
    wait_slot(2);
    send(24'hABCDEF, 24'hFEDCBA);
    send(24'h0F0F0F, 24'hF0F0F0);
    check_eq("s5_queued", pend_q.size(), 2);
    wait_slot(40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s5_rst_ws", i2s_ws, 1'b0);
    check_eq("s5_rst_ready", sample_ready, 1'b1);
    run(130);

    // Scenario 6: randomised traffic at several offered loads, rare resets
    for (int chunk = 0; chunk < 6; chunk++) begin
      case (chunk % 3)
        0:       p = 3;
        1:       p = 30;
        default: p = 100;
      endcase
      for (int i = 0; i < 600; i++) begin
        sample_valid = ($urandom_range(0, 99) < p);
        sample_left  = DS'($urandom());
        sample_right = DS'($urandom());
        rst          = ($urandom_range(0, 999) == 0);
        tick();
      end
      rst = 1'b0;
    end
    sample_valid = 1'b0;
    run(130);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
